// File: rtl/manta_pkg.sv
// Shared types and constants for the manta boot/flush sequencer.
package manta_pkg;

  typedef enum logic [1:0] {
    StHold,
    StDrain,
    StClear,
    StRun
  } boot_state_t;

  localparam logic [15:0] ResetPcDefault  = 16'h0000;
  localparam logic [15:0] NopInstrDefault = 16'h0000;

  // Width of a register index, never narrower than one bit.
  function automatic int unsigned addr_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/manta_boot_ctrl.sv
// Boot/flush sequencer: holds PC, injects NOPs, clears the register file,
// then hands control to the core. Outputs decode from registered state only.
module manta_boot_ctrl
  import manta_pkg::*;
#(
  parameter int unsigned          DATA_W       = 16,
  parameter int unsigned          NREGS        = 16,
  parameter int unsigned          FLUSH_CYCLES = 9,
  parameter int unsigned          NOP_CYCLES   = 10,
  parameter logic [DATA_W-1:0]    RESET_PC     = DATA_W'(ResetPcDefault),
  parameter logic [DATA_W-1:0]    NOP_INSTR    = DATA_W'(NopInstrDefault)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           pc_hold,
  output logic [DATA_W-1:0]              pc_value,
  output logic                           instr_override,
  output logic [DATA_W-1:0]              instr_value,
  output logic                           rf_clr_we,
  output logic [addr_width(NREGS)-1:0]   rf_clr_addr,
  output logic [DATA_W-1:0]              rf_clr_data,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned CntMax = (NOP_CYCLES > NREGS) ? NOP_CYCLES : NREGS;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned AddrW  = addr_width(NREGS);

  localparam logic [CntW-1:0] FlushLast = CntW'(FLUSH_CYCLES - 1);
  localparam logic [CntW-1:0] NopLast   = CntW'(NOP_CYCLES - 1);
  localparam logic [CntW-1:0] RegLast   = CntW'(NREGS - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  if (FLUSH_CYCLES == 0 || NOP_CYCLES < FLUSH_CYCLES || NREGS == 0) begin : gen_param_err
    $error("manta_boot_ctrl: need FLUSH_CYCLES>=1, NOP_CYCLES>=FLUSH_CYCLES, NREGS>=1");
  end

  boot_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHold;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StHold: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_q == FlushLast) begin
          // With no drain window the count restarts for the clear phase.
          if (FLUSH_CYCLES == NOP_CYCLES) begin
            state_d = StClear;
            cnt_d   = '0;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_q == NopLast) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_q == RegLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (start) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StHold;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pc_hold        = 1'b0;
    instr_override = 1'b0;
    rf_clr_we      = 1'b0;
    rf_clr_addr    = '0;
    busy           = 1'b1;
    done           = 1'b0;
    unique case (state_q)
      StHold: begin
        pc_hold        = 1'b1;
        instr_override = 1'b1;
      end
      StDrain: begin
        instr_override = 1'b1;
      end
      StClear: begin
        rf_clr_we   = 1'b1;
        rf_clr_addr = cnt_q[AddrW-1:0];
      end
      StRun: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: begin
        pc_hold        = 1'b1;
        instr_override = 1'b1;
      end
    endcase
  end

  assign pc_value    = RESET_PC;
  assign instr_value = NOP_INSTR;
  assign rf_clr_data = '0;

endmodule

// File: tb/tb_manta_boot_ctrl.sv
// Directed bench for manta_boot_ctrl: three parameterisations share clock and reset.
module tb_manta_boot_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b, start_c;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // DUT a: default parameters
  logic        ph_a, io_a, we_a, busy_a, done_a;
  logic [15:0] pv_a, iv_a, dat_a;
  logic [3:0]  addr_a;

  manta_boot_ctrl u_dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start_a),
    .pc_hold       (ph_a),
    .pc_value      (pv_a),
    .instr_override(io_a),
    .instr_value   (iv_a),
    .rf_clr_we     (we_a),
    .rf_clr_addr   (addr_a),
    .rf_clr_data   (dat_a),
    .busy          (busy_a),
    .done          (done_a)
  );

  // DUT b: no drain window
  logic        ph_b, io_b, we_b, busy_b, done_b;
  logic [15:0] pv_b, iv_b, dat_b;
  logic [2:0]  addr_b;

  manta_boot_ctrl #(
    .NREGS       (8),
    .FLUSH_CYCLES(4),
    .NOP_CYCLES  (4)
  ) u_dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start_b),
    .pc_hold       (ph_b),
    .pc_value      (pv_b),
    .instr_override(io_b),
    .instr_value   (iv_b),
    .rf_clr_we     (we_b),
    .rf_clr_addr   (addr_b),
    .rf_clr_data   (dat_b),
    .busy          (busy_b),
    .done          (done_b)
  );

  // DUT c: minimal sequence
  logic        ph_c, io_c, we_c, busy_c, done_c;
  logic [15:0] pv_c, iv_c, dat_c;
  logic [0:0]  addr_c;

  manta_boot_ctrl #(
    .NREGS       (1),
    .FLUSH_CYCLES(1),
    .NOP_CYCLES  (1)
  ) u_dut_c (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start_c),
    .pc_hold       (ph_c),
    .pc_value      (pv_c),
    .instr_override(io_c),
    .instr_value   (iv_c),
    .rf_clr_we     (we_c),
    .rf_clr_addr   (addr_c),
    .rf_clr_data   (dat_c),
    .busy          (busy_c),
    .done          (done_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs e edges after a (re)start, for flush f, nop n, regs r.
  task automatic check_seq(input string name, input int e, input int f, input int n,
                           input int r, input logic ph, input logic io, input logic we,
                           input logic [3:0] addr, input logic bsy, input logic dn,
                           input logic [15:0] pv, input logic [15:0] iv,
                           input logic [15:0] dat);
    logic        x_we, x_dn;
    logic [31:0] x_addr;
    string       t;
    x_we   = (e >= n) && (e < n + r);
    x_dn   = (e >= n + r);
    x_addr = x_we ? 32'(e - n) : 32'd0;
    t      = $sformatf("%s e=%0d", name, e);
    chk({t, " pc_hold"}, {31'd0, ph}, {31'd0, e < f});
    chk({t, " instr_override"}, {31'd0, io}, {31'd0, e < n});
    chk({t, " rf_clr_we"}, {31'd0, we}, {31'd0, x_we});
    chk({t, " rf_clr_addr"}, {28'd0, addr}, x_addr);
    chk({t, " busy"}, {31'd0, bsy}, {31'd0, !x_dn});
    chk({t, " done"}, {31'd0, dn}, {31'd0, x_dn});
    chk({t, " pc_value"}, {16'd0, pv}, 32'h0000);
    chk({t, " instr_value"}, {16'd0, iv}, 32'h0000);
    chk({t, " rf_clr_data"}, {16'd0, dat}, 32'h0000);
  endtask

  task automatic check_all(input string phase, input int e);
    check_seq({phase, " a"}, e, 9, 10, 16, ph_a, io_a, we_a, addr_a, busy_a, done_a,
              pv_a, iv_a, dat_a);
    check_seq({phase, " b"}, e, 4, 4, 8, ph_b, io_b, we_b, {1'b0, addr_b}, busy_b, done_b,
              pv_b, iv_b, dat_b);
    check_seq({phase, " c"}, e, 1, 1, 1, ph_c, io_c, we_c, {3'b0, addr_c}, busy_c, done_c,
              pv_c, iv_c, dat_c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;

    // Cold boot: reset low for 3 cycles, released just after an edge.
    repeat (3) step();
    rst_n = 1'b1;
    check_all("boot", 0);
    for (int e = 1; e <= 26; e++) begin
      step();
      check_all("boot", e);
    end

    // Restart pulse in RUN.
    start_a = 1'b1;
    start_b = 1'b1;
    start_c = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    check_all("restart", 0);
    for (int e = 1; e <= 26; e++) begin
      step();
      check_all("restart", e);
    end

    // start held high while sequencing must be ignored.
    rst_n = 1'b0;
    repeat (2) step();
    rst_n   = 1'b1;
    start_a = 1'b1;
    start_b = 1'b1;
    check_all("heldstart", 0);
    for (int e = 1; e <= 26; e++) begin
      step();
      check_all("heldstart", e);
      start_a = (e < 25);
      start_b = (e < 11);
    end
    start_a = 1'b0;
    start_b = 1'b0;

    // Abort mid-clear (a at addr 5), then full sequence from scratch.
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      step();
      check_all("preabort", e);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_all("inreset", 0);
    repeat (2) step();
    rst_n = 1'b1;
    check_all("reboot", 0);
    for (int e = 1; e <= 26; e++) begin
      step();
      check_all("reboot", e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/manta_boot_ctrl.md
# manta_boot_ctrl

Parametrised boot/flush sequencer for the manta_style processor. It replaces bench-side force/release initialisation with synthesizable logic. After reset or a restart request it:
- holds the PC at a reset vector;
- injects NOP instructions into the decode stage to flush the pipeline;
- clears every register-file entry through a dedicated write port;
- hands control to the core.

It sits between the core's reset domain and its PC mux, ID instruction mux and register-file write arbiter.

## Interface
Parameters:
- DATA_W, 16, instruction/PC/register width
- NREGS, 16, number of GPRs to clear (≥1)
- FLUSH_CYCLES, 9, clock periods PC is held at RESET_PC (≥1)
- NOP_CYCLES, 10, clock periods NOPs are injected (≥FLUSH_CYCLES)
- RESET_PC, 16'h0000, PC value driven while held
- NOP_INSTR, 16'h0000, instruction injected while overriding

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  restart request; sampled only in RUN
- pc_hold  out  1  core PC mux selects pc_value
- pc_value  out  DATA_W  constant RESET_PC
- instr_override  out  1  ID mux selects instr_value
- instr_value  out  DATA_W  constant NOP_INSTR
- rf_clr_we  out  1  register-file clear write enable (priority over core writes)
- rf_clr_addr  out  $clog2(NREGS) (min 1)  GPR index being cleared
- rf_clr_data  out  DATA_W  constant zero
- busy  out  1  sequence in progress
- done  out  1  core running normally

## Operation
- Moore FSM, states HOLD, DRAIN, CLEAR, RUN. One counter cnt, width $clog2(max(NOP_CYCLES, NREGS)+1).
- Reset (rst_n low, asynchronous): state=HOLD, cnt=0.
  - Outputs during reset: pc_hold=1, instr_override=1, rf_clr_we=0, rf_clr_addr=0, busy=1, done=0.
- HOLD:
  - Outputs: pc_hold=1, instr_override=1, busy=1.
  - cnt increments each edge.
  - When cnt==FLUSH_CYCLES-1: go to DRAIN, or directly to CLEAR with cnt=0 if FLUSH_CYCLES==NOP_CYCLES.
- DRAIN:
  - Outputs: pc_hold=0, instr_override=1.
  - cnt increments each edge.
  - When cnt==NOP_CYCLES-1: go to CLEAR, cnt=0.
- CLEAR:
  - Outputs: pc_hold=0, instr_override=0, rf_clr_we=1, rf_clr_addr=cnt.
  - When cnt==NREGS-1: go to RUN, cnt=0.
- RUN:
  - Outputs: done=1, busy=0, all override outputs 0.
  - start=1 on a rising edge: go to HOLD, cnt=0.
- start is ignored in HOLD, DRAIN and CLEAR. No queuing, no extension of the sequence.
- rst_n asserted in any state aborts immediately to HOLD, cnt=0. A partial clear is not resumed.
- Elaboration error if FLUSH_CYCLES<1, NOP_CYCLES<FLUSH_CYCLES or NREGS<1.

## Timing
- All outputs are decoded from registered state/cnt only. No combinational path from start.
- Default parameters, counting rising edges after rst_n deassertion:
  - pc_hold high through edge 9, low after edge 9;
  - instr_override low after edge 10;
  - rf_clr_we high for the periods following edges 10..25, rf_clr_addr 0..15 in order;
  - done=1 after edge 26.
- General boot length: NOP_CYCLES+NREGS periods from reset release to done.
- Restart: start sampled high at edge k in RUN gives pc_hold=1, busy=1, done=0 after edge k. done returns after edge k+NOP_CYCLES+NREGS.
- rst_n deassertion is assumed synchronised externally. The first counted edge is the first edge with rst_n high.

## Structure
- Shared package manta_pkg holds:
  - the FSM state enum (boot_state_t);
  - the NOP_INSTR default;
  - the RESET_PC default.
- No sub-module needed. A single file with one always_ff for state/cnt and one always_comb output decode.

## Test plan
- Default parameters, rst_n low 3 cycles then high:
  - pc_hold=1 for exactly 9 periods;
  - instr_override=1 for exactly 10 periods, instr_value=16'h0000;
  - 16 clear writes, addr 0→15, data 0;
  - done=1 at edge 26.
- FLUSH_CYCLES=NOP_CYCLES=4, NREGS=8: DRAIN never entered; pc_hold and instr_override fall together after edge 4; done after edge 12.
- start pulsed in RUN: busy rises next edge and the full sequence repeats, ending with done after 26 further edges.
- start held high during HOLD/CLEAR: sequence timing identical to no-start run; no restart occurs.
- rst_n asserted mid-CLEAR (addr=5): outputs return to reset values asynchronously; after release the full 26-period sequence restarts from addr 0.
- NREGS=1, FLUSH_CYCLES=1, NOP_CYCLES=1: one hold period, then one clear write to addr 0, then done after edge 2.
